// File: rtl/cups_pkg.sv
// Shared fetch-stage types and defaults: FSM state encoding, PC width and the
// bubble encoding that also serves as the IF/ID reset value.
package cups_pkg;

    localparam int          PC_W         = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [15:0]     instr;
    } fetch_ent_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next fetch-PC select: redirect target beats sequential increment beats hold.
// Addition wraps modulo 2^16 with no fault.
module fetch_pc_gen
    import cups_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_INC = 16'd2
) (
    input  logic [PC_W-1:0] i_cur_pc,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_cur_pc;
        if (i_redirect)
            o_next_pc = i_redirect_pc;
        else if (i_inc)
            o_next_pc = i_cur_pc + PC_INC;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding imem request/ack, one-entry skid
// buffer for stalls, flush on redirect. Optional IF_PERF_CNT_EN adds stallCycles.
module if_fetch
    import cups_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [PC_W-1:0] PC_INC    = 16'd2,
    parameter logic [15:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirectPC,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     instruction,
    output logic            valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]     stallCycles
`endif
);

    fetch_state_t    r_state, w_next_state;
    logic [PC_W-1:0] r_fetch_pc, w_next_pc;
    logic [PC_W-1:0] r_addr;
    fetch_ent_t      r_skid;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_instr;
    logic            r_valid;

    logic            w_inc;
    logic            w_deliver;
    logic            w_skid_load;
    fetch_ent_t      w_dlv;

    always_comb begin
        w_next_state = r_state;
        w_inc        = 1'b0;
        w_deliver    = 1'b0;
        w_skid_load  = 1'b0;
        w_dlv        = '{pc: r_fetch_pc, instr: imem_data};
        case (r_state)
            IDLE: w_next_state = REQ;
            REQ: begin
                if (redirect) begin
                    // An un-acked request cannot be withdrawn, so its data must be drained.
                    w_next_state = imem_ack ? REQ : DRAIN;
                end else if (imem_ack) begin
                    w_inc = 1'b1;
                    if (stall) begin
                        w_skid_load  = 1'b1;
                        w_next_state = HOLD;
                    end else begin
                        w_deliver = 1'b1;
                    end
                end
            end
            DRAIN: if (imem_ack) w_next_state = REQ;
            HOLD: begin
                if (redirect) begin
                    w_next_state = REQ;
                end else if (!stall) begin
                    w_deliver    = 1'b1;
                    w_dlv        = r_skid;
                    w_next_state = REQ;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    fetch_pc_gen #(.PC_INC(PC_INC)) u_pc_gen (
        .i_cur_pc      (r_fetch_pc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPC),
        .i_inc         (w_inc),
        .o_next_pc     (w_next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_skid     <= '0;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            // Remember the issued address so DRAIN keeps it stable after fetchPC moves.
            if (r_state == REQ)
                r_addr <= r_fetch_pc;
            if (redirect)
                r_skid <= '0;
            else if (w_skid_load)
                r_skid <= '{pc: r_fetch_pc, instr: imem_data};
            if (redirect) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (!stall) begin
                if (w_deliver) begin
                    r_pc    <= w_dlv.pc;
                    r_instr <= w_dlv.instr;
                    r_valid <= 1'b1;
                end else begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign imem_req    = (r_state == REQ) || (r_state == DRAIN);
    assign imem_addr   = (r_state == DRAIN) ? r_addr : r_fetch_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign valid       = r_valid;

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if ((stall || r_state == DRAIN) && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed reset/stream/stall/redirect/wrap scenarios, then
// random stall/redirect/ack traffic checked against a program-order stream model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ack_en = 1'b0;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] pc, instr;
    logic        valid;

    // Second instance: RESET_PC at the top of the address space, always acked.
    logic        w_zero1 = 1'b0;
    logic [15:0] w_zero16 = 16'h0000;
    logic        req_w, ack_w, valid_w;
    logic [15:0] addr_w, data_w, pc_w, instr_w;

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cycles, stall_cycles_w;
    logic [15:0] snap;
`endif

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    assign imem_ack  = imem_req & ack_en;
    assign imem_data = memfn(imem_addr);
    assign ack_w     = req_w;
    assign data_w    = memfn(addr_w);

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect),
        .redirectPC(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc),
        .instruction(instr), .valid(valid)
`ifdef IF_PERF_CNT_EN
        , .stallCycles(stall_cycles)
`endif
    );

    if_fetch #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .reset(rst_n), .stall(w_zero1), .redirect(w_zero1),
        .redirectPC(w_zero16), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_data(data_w), .pc(pc_w),
        .instruction(instr_w), .valid(valid_w)
`ifdef IF_PERF_CNT_EN
        , .stallCycles(stall_cycles_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_next, tgt;
    logic [15:0] p_pc, p_ins, p_addr;
    logic        p_v, p_req, p_ack, st, rd, stuck;
    int          idle;

    initial begin
        // reset state
        repeat (3) tick;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc_w", pc_w, 16'hFFFE);
`ifdef IF_PERF_CNT_EN
        chk("rst_cnt", stall_cycles, 16'h0000);
`endif
        rst_n  = 1'b1;
        ack_en = 1'b1;
        tick;
        chk("t1_req", imem_req, 1'b1);
        chk("t1_addr", imem_addr, 16'h0000);
        chk("t1_valid", valid, 1'b0);

        // streaming with same-cycle ack
        tick;
        chk("t2_a1", {pc, instr, 15'd0, valid}, {16'h0000, memfn(16'h0000), 16'd1});
        chk("t6_wrap_a", {pc_w, instr_w, 15'd0, valid_w}, {16'hFFFE, memfn(16'hFFFE), 16'd1});
        tick;
        chk("t2_a2", {pc, instr, 15'd0, valid}, {16'h0002, memfn(16'h0002), 16'd1});
        chk("t6_wrap_b", {pc_w, instr_w, 15'd0, valid_w}, {16'h0000, memfn(16'h0000), 16'd1});
        tick;
        chk("t2_a3", {pc, instr, 15'd0, valid}, {16'h0004, memfn(16'h0004), 16'd1});

        // stall on the acking cycle: skid the data, outputs frozen
        stall = 1'b1;
        tick;
        chk("t3_hold", {pc, instr, 15'd0, valid}, {16'h0004, memfn(16'h0004), 16'd1});
        chk("t3_req_drop", imem_req, 1'b0);
        stall = 1'b0;
        tick;
        chk("t3_skid_out", {pc, instr, 15'd0, valid}, {16'h0006, memfn(16'h0006), 16'd1});
        chk("t3_next_req", {15'd0, imem_req, imem_addr}, {16'd1, 16'h0008});

        // redirect while an ack is pending
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick;
        redirect = 1'b0;
        chk("t4_flush", {instr, 15'd0, valid}, {16'h0000, 16'd0});
        chk("t4_drain_addr", {15'd0, imem_req, imem_addr}, {16'd1, 16'h0008});
        tick;
        chk("t4_drain_wait", {15'd0, imem_req, imem_addr, 15'd0, valid}, {16'd1, 16'h0008, 16'd0});
        ack_en = 1'b1;
        tick;
        chk("t4_discard", {15'd0, valid, 15'd0, imem_req, imem_addr}, {16'd0, 16'd1, 16'h0040});
        tick;
        chk("t4_target", {pc, instr, 15'd0, valid}, {16'h0040, memfn(16'h0040), 16'd1});

        // redirect + stall + ack together
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 16'h0040;
        tick;
        redirect = 1'b0;
        stall    = 1'b0;
        chk("t5_flush", {instr, 15'd0, valid}, {16'h0000, 16'd0});
        chk("t5_addr", {15'd0, imem_req, imem_addr}, {16'd1, 16'h0040});
        tick;
        chk("t5_no_skid", {pc, instr, 15'd0, valid}, {16'h0040, memfn(16'h0040), 16'd1});

        ack_en = 1'b0;
        tick;
`ifdef IF_PERF_CNT_EN
        snap  = stall_cycles;
        stall = 1'b1;
        repeat (3) tick;
        stall = 1'b0;
        chk("t6_stall_cnt", stall_cycles - snap, 16'd3);
`endif

        // random traffic against the program-order model
        exp_next = 16'h0042;
        idle     = 0;
        stuck    = 1'b0;
        for (int i = 0; i < 800 && !stuck; i++) begin
            st = ($urandom % 4) == 0;
            rd = ($urandom % 10) == 0;
            tgt = 16'($urandom) & 16'hFFFE;
            if (($urandom % 4) == 0) tgt = 16'hFFFA;
            stall       = st;
            redirect    = rd;
            redirect_pc = tgt;
            ack_en      = ($urandom % 5) < 3;
            p_pc   = pc;
            p_ins  = instr;
            p_v    = valid;
            p_req  = imem_req;
            p_addr = imem_addr;
            p_ack  = imem_req & ack_en;
            tick;
            if (rd) begin
                chk("rnd_flush", {instr, 15'd0, valid}, {16'h0000, 16'd0});
                exp_next = tgt;
            end else if (st) begin
                chk("rnd_frozen", {pc, instr}, {p_pc, p_ins});
                chk("rnd_frozen_v", valid, p_v);
            end else if (valid) begin
                chk("rnd_seq_pc", pc, exp_next);
                chk("rnd_data", instr, memfn(pc));
                exp_next = pc + 16'd2;
            end else begin
                chk("rnd_bubble", instr, 16'h0000);
            end
            if (p_req && !p_ack)
                chk("rnd_req_hold", {15'd0, imem_req, imem_addr}, {16'd1, p_addr});
            if (!rd && !st && valid)
                idle = 0;
            else
                idle++;
            if (idle > 200) begin
                chk("rnd_progress", 0, 1);
                stuck = 1'b1;
            end
        end
        stall    = 1'b0;
        redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
